// File: rtl/tdm_demux_1x4_if.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux_1x4_if
//  Purpose  : Bus bundle for the 1:4 TDM demultiplexer. It carries the
//             serial word stream into the block and the four demultiplexed
//             channel words, strobes and status back out.
//  Signals  : in_valid, in_sof, in_data        - TDM word stream (to demux)
//             out0..out3                       - registered channel words
//             out_valid[3:0]                   - per-channel update strobe
//             frame_valid, frame_err           - frame status pulses
//             slot[1:0]                        - next expected slot index
//  Modports : master - stream source / result consumer
//             slave  - the demultiplexer itself
//  Revision : 1.0  initial release
// ============================================================================
interface tdm_demux_1x4_if #(
    parameter int BITS = 4
);
    logic            in_valid;
    logic            in_sof;
    logic [BITS-1:0] in_data;
    logic [BITS-1:0] out0;
    logic [BITS-1:0] out1;
    logic [BITS-1:0] out2;
    logic [BITS-1:0] out3;
    logic [3:0]      out_valid;
    logic            frame_valid;
    logic            frame_err;
    logic [1:0]      slot;

    modport master (
        output in_valid, in_sof, in_data,
        input  out0, out1, out2, out3, out_valid, frame_valid, frame_err, slot
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out0, out1, out2, out3, out_valid, frame_valid, frame_err, slot
    );
endinterface
`default_nettype wire

// File: rtl/tdm_demux_1x4.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux_1x4
//  Purpose  : Receive-side 1:4 time-division demultiplexer. Each frame is four
//             words, the first marked by in_sof. Every accepted word is
//             steered to its channel register with one cycle of latency, and
//             frame completion / premature-SOF errors are pulsed.
//  Ports    : clk    - system clock, rising edge
//             rst_n  - synchronous active-low reset
//             bus    - tdm_demux_1x4_if.slave (stream in, channels out)
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux_1x4 #(
    parameter int BITS = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    tdm_demux_1x4_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_slot;
    logic [1:0]      w_slot_next;
    logic [3:0]      w_wr;
    logic            w_frame_valid;
    logic            w_frame_err;

    logic [BITS-1:0] r_out [4];
    logic [3:0]      r_out_valid;
    logic            r_frame_valid;
    logic            r_frame_err;

    // Next-state and write-select decode.
    always_comb begin
        w_state_next  = r_state;
        w_slot_next   = r_slot;
        w_wr          = 4'b0000;
        w_frame_valid = 1'b0;
        w_frame_err   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Words without SOF are orphans and silently dropped here.
                if (bus.in_valid && bus.in_sof) begin
                    w_wr         = 4'b0001;
                    w_slot_next  = 2'd1;
                    w_state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (bus.in_valid) begin
                    if (bus.in_sof) begin
                        // Premature SOF: abandon the partial frame and restart
                        // at slot 0 with this word.
                        w_frame_err = 1'b1;
                        w_wr        = 4'b0001;
                        w_slot_next = 2'd1;
                    end else begin
                        w_wr = 4'b0001 << r_slot;
                        if (r_slot == 2'd3) begin
                            w_frame_valid = 1'b1;
                            w_slot_next   = 2'd0;
                            w_state_next  = ST_IDLE;
                        end else begin
                            w_slot_next = r_slot + 2'd1;
                        end
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_slot_next  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_slot        <= 2'd0;
            r_out_valid   <= 4'b0000;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_out[k] <= '0;
            end
        end else begin
            r_state       <= w_state_next;
            r_slot        <= w_slot_next;
            r_out_valid   <= w_wr;
            r_frame_valid <= w_frame_valid;
            r_frame_err   <= w_frame_err;
            for (int k = 0; k < 4; k++) begin
                if (w_wr[k]) begin
                    r_out[k] <= bus.in_data;
                end
            end
        end
    end

    assign bus.out0        = r_out[0];
    assign bus.out1        = r_out[1];
    assign bus.out2        = r_out[2];
    assign bus.out3        = r_out[3];
    assign bus.out_valid   = r_out_valid;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_err   = r_frame_err;
    assign bus.slot        = r_slot;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_1x4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux_1x4
//  Purpose  : Self-checking bench for tdm_demux_1x4. Stimulus pushes the
//             hand-computed expected strobe/data for every word that should
//             produce output; a monitor pops and compares whenever the DUT
//             raises any strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux_1x4;

    typedef struct packed {
        logic [3:0] ov;
        logic [3:0] d;
        logic       fv;
        logic       fe;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    exp_t exp_q [$];
    int   fv_cyc [$];

    tdm_demux_1x4_if #(.BITS(4)) bus ();

    tdm_demux_1x4 #(.BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pick(input logic [3:0] ov);
        case (ov)
            4'b0001: return bus.out0;
            4'b0010: return bus.out1;
            4'b0100: return bus.out2;
            default: return bus.out3;
        endcase
    endfunction

    // Monitor: any strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.out_valid !== 4'b0000 || bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            if (bus.frame_valid === 1'b1) fv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got ov=%b fv=%b fe=%b expected none (t=%0t)",
                         bus.out_valid, bus.frame_valid, bus.frame_err, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_valid",   16'(bus.out_valid),   16'(e.ov));
                chk("frame_valid", 16'(bus.frame_valid), 16'(e.fv));
                chk("frame_err",   16'(bus.frame_err),   16'(e.fe));
                chk("chan_data",   16'(pick(e.ov)),      16'(e.d));
            end
        end
    end

    task automatic send(input logic sof, input logic [3:0] d,
                        input logic [3:0] eov, input logic efv, input logic efe);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = d;
        if (eov != 4'b0000) exp_q.push_back('{eov, d, efv, efe});
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
            bus.in_data  = 4'hF;
        end
    endtask

    // Gap cycles where the slot counter must hold a known value.
    task automatic gap_slot(input int n, input logic [1:0] es);
        repeat (n) begin
            gap(1);
            chk("slot_gap", 16'(bus.slot), 16'(es));
        end
    endtask

    task automatic chk_outs(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        chk("out0", 16'(bus.out0), 16'(a));
        chk("out1", 16'(bus.out1), 16'(b));
        chk("out2", 16'(bus.out2), 16'(c));
        chk("out3", 16'(bus.out3), 16'(d));
    endtask

    task automatic frame4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        send(1'b1, a, 4'b0001, 1'b0, 1'b0);
        send(1'b0, b, 4'b0010, 1'b0, 1'b0);
        send(1'b0, c, 4'b0100, 1'b0, 1'b0);
        send(1'b0, d, 4'b1000, 1'b1, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = 4'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_outs(4'h0, 4'h0, 4'h0, 4'h0);
        chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
        chk("rst_slot",      16'(bus.slot),      16'h0);
        chk("rst_fv_fe",     16'({bus.frame_valid, bus.frame_err}), 16'h0);
        rst_n = 1'b1;

        // Plain frame
        frame4(4'hA, 4'h5, 4'h9, 4'hC);
        gap(1);
        chk_outs(4'hA, 4'h5, 4'h9, 4'hC);
        chk("slot_end1", 16'(bus.slot), 16'h0);

        // Same frame with 3-cycle gaps
        send(1'b1, 4'hA, 4'b0001, 1'b0, 1'b0);
        gap_slot(3, 2'd1);
        send(1'b0, 4'h5, 4'b0010, 1'b0, 1'b0);
        gap_slot(3, 2'd2);
        send(1'b0, 4'h9, 4'b0100, 1'b0, 1'b0);
        gap_slot(3, 2'd3);
        send(1'b0, 4'hC, 4'b1000, 1'b1, 1'b0);
        gap_slot(1, 2'd0);
        chk_outs(4'hA, 4'h5, 4'h9, 4'hC);

        // Orphan data in IDLE
        send(1'b0, 4'h7, 4'b0000, 1'b0, 1'b0);
        send(1'b0, 4'h3, 4'b0000, 1'b0, 1'b0);
        gap(1);
        chk("orphan_slot", 16'(bus.slot), 16'h0);
        frame4(4'h1, 4'h2, 4'h3, 4'h4);
        gap(1);
        chk_outs(4'h1, 4'h2, 4'h3, 4'h4);

        // Premature SOF
        send(1'b1, 4'h1, 4'b0001, 1'b0, 1'b0);
        send(1'b0, 4'h2, 4'b0010, 1'b0, 1'b0);
        send(1'b1, 4'hE, 4'b0001, 1'b0, 1'b1);
        send(1'b0, 4'hF, 4'b0010, 1'b0, 1'b0);
        send(1'b0, 4'h0, 4'b0100, 1'b0, 1'b0);
        send(1'b0, 4'h8, 4'b1000, 1'b1, 1'b0);
        gap(1);
        chk_outs(4'hE, 4'hF, 4'h0, 4'h8);

        // Back-to-back frames
        gap(2);
        fv_cyc.delete();
        frame4(4'h1, 4'h2, 4'h3, 4'h4);
        frame4(4'h5, 4'h6, 4'h7, 4'h8);
        gap(2);
        chk_outs(4'h5, 4'h6, 4'h7, 4'h8);
        chk("b2b_fv_count", 16'(fv_cyc.size()), 16'd2);
        if (fv_cyc.size() == 2)
            chk("b2b_fv_spacing", 16'(fv_cyc[1] - fv_cyc[0]), 16'd4);

        // Reset mid-frame
        send(1'b1, 4'h9, 4'b0001, 1'b0, 1'b0);
        send(1'b0, 4'hA, 4'b0010, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_outs(4'h0, 4'h0, 4'h0, 4'h0);
        chk("midrst_slot", 16'(bus.slot), 16'h0);
        send(1'b0, 4'hB, 4'b0000, 1'b0, 1'b0);
        frame4(4'h1, 4'h2, 4'h3, 4'h4);
        gap(3);
        chk_outs(4'h1, 4'h2, 4'h3, 4'h4);
        chk("queue_empty", 16'(exp_q.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
